// File: rtl/proc_pkg.sv
// Shared opcodes, step encodings and instruction-field layout for the bus-datapath sequencer.
package proc_pkg;

  localparam int DATA_W = 16;
  localparam int NREG   = 8;
  localparam int RA_W   = 3;
  localparam int OP_W   = 3;

  // The instruction occupies the top IR_W bits of iin as {op, rx, ry}
  localparam int IR_W   = OP_W + 2 * RA_W;
  localparam int OP_LSB = 2 * RA_W;
  localparam int RX_LSB = RA_W;
  localparam int RY_LSB = 0;

  localparam logic [OP_W-1:0] OP_MV   = 3'b000;
  localparam logic [OP_W-1:0] OP_MVI  = 3'b001;
  localparam logic [OP_W-1:0] OP_ADD  = 3'b010;
  localparam logic [OP_W-1:0] OP_SUB  = 3'b011;
  localparam logic [OP_W-1:0] OP_MVNZ = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_T1   = 2'd1,
    S_T2   = 2'd2,
    S_T3   = 2'd3
  } state_t;

endpackage

// File: rtl/seq_dec3to8.sv
// Register-address to one-hot decoder with enable; purely combinational.
module seq_dec3to8 #(
  parameter int RA_W = 3,
  parameter int NREG = 8
) (
  input  logic            en,
  input  logic [RA_W-1:0] addr,
  output logic [NREG-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[addr] = 1'b1;
  end

endmodule

// File: rtl/proc_sequencer.sv
// Multi-cycle control sequencer: latches an instruction on run and steps T1..T3 driving bus selects/enables.
// run->done is 1 cycle (mv/mvi/mvnz/illegal) or 3 cycles (add/sub); run is only sampled in IDLE or the done step.
module proc_sequencer
  import proc_pkg::*;
#(
  parameter int DATA_W = proc_pkg::DATA_W,
  parameter int NREG   = proc_pkg::NREG,
  parameter int RA_W   = proc_pkg::RA_W,
  parameter int OP_W   = proc_pkg::OP_W
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              run,
  input  logic [DATA_W-1:0] iin,
  input  logic              g_nz,
  output logic [NREG-1:0]   rsel,
  output logic              g_sel,
  output logic              imm_sel,
  output logic [NREG-1:0]   rin,
  output logic              ain,
  output logic              gin,
  output logic              alu_sub,
  output logic              busy,
  output logic              done,
  output logic              illegal
);

  state_t                state, state_nxt;
  logic [IR_W-1:0]       ir;
  logic [IR_W-1:0]       ir_fld;
  logic [OP_W-1:0]       op;
  logic [RA_W-1:0]       rx, ry;
  logic                  latch;
  logic                  last_step;
  logic                  sel_en, rin_en;
  logic [RA_W-1:0]       sel_addr;
  logic                  unused_iin;

  assign ir_fld     = iin[DATA_W-1 -: IR_W];
  assign unused_iin = ^iin[DATA_W-IR_W-1:0];
  assign op         = ir[OP_LSB +: OP_W];
  assign rx         = ir[RX_LSB +: RA_W];
  assign ry         = ir[RY_LSB +: RA_W];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      if (latch) ir <= ir_fld;
    end
  end

  always_comb begin
    state_nxt = state;
    latch     = 1'b0;
    last_step = 1'b0;
    sel_en    = 1'b0;
    sel_addr  = ry;
    rin_en    = 1'b0;
    g_sel     = 1'b0;
    imm_sel   = 1'b0;
    ain       = 1'b0;
    gin       = 1'b0;
    alu_sub   = 1'b0;
    done      = 1'b0;
    illegal   = 1'b0;

    case (state)
      S_IDLE: begin
        if (run) begin
          latch     = 1'b1;
          state_nxt = S_T1;
        end
      end
      S_T1: begin
        case (op)
          OP_MV: begin
            sel_en    = 1'b1;
            rin_en    = 1'b1;
            last_step = 1'b1;
          end
          OP_MVI: begin
            imm_sel   = 1'b1;
            rin_en    = 1'b1;
            last_step = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            sel_addr  = rx;
            sel_en    = 1'b1;
            ain       = 1'b1;
            state_nxt = S_T2;
          end
          OP_MVNZ: begin
            sel_en    = g_nz;
            rin_en    = g_nz;
            last_step = 1'b1;
          end
          default: begin
            illegal   = 1'b1;
            last_step = 1'b1;
          end
        endcase
      end
      S_T2: begin
        sel_en    = 1'b1;
        gin       = 1'b1;
        alu_sub   = (op == OP_SUB);
        state_nxt = S_T3;
      end
      S_T3: begin
        g_sel     = 1'b1;
        rin_en    = 1'b1;
        last_step = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase

    // Done step doubles as the accept slot so back-to-back instructions have no bubble
    if (last_step) begin
      done = 1'b1;
      if (run) begin
        latch     = 1'b1;
        state_nxt = S_T1;
      end else begin
        state_nxt = S_IDLE;
      end
    end
  end

  assign busy = (state != S_IDLE);

  seq_dec3to8 #(.RA_W(RA_W), .NREG(NREG)) u_dec_rsel (
    .en     (sel_en),
    .addr   (sel_addr),
    .onehot (rsel)
  );

  seq_dec3to8 #(.RA_W(RA_W), .NREG(NREG)) u_dec_rin (
    .en     (rin_en),
    .addr   (rx),
    .onehot (rin)
  );

endmodule
